// File: rtl/cpudefs_pkg.sv
// ---------------------------------------------------------------------------
// cpudefs -- shared definitions for the CPU front end.
//
// Purpose:
//   Holds the fetch state machine encoding, the instruction width and the
//   default reset vector so the fetch stage and anything that talks to it
//   agree on the same numbers.
//
// Contents:
//   INSTR_WIDTH          width of an instruction word / address in bits
//   DEFAULT_RESET_VECTOR PC loaded on reset unless the parent overrides it
//   fetch_state_t        states of the instruction fetch controller
//   isWordAligned()      true when an address sits on a 4-byte boundary
// ---------------------------------------------------------------------------
package cpudefs;

  localparam int unsigned INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // S_REQUEST : drive a single read request for the current PC
  // S_WAIT    : request outstanding, waiting for the memory response
  // S_HOLD    : fetched word presented to decode until it is accepted
  // S_DRAIN   : redirected while a response was still owed; swallow it
  // S_FAULT   : misaligned redirect target, fetch parked until redirected
  typedef enum logic [2:0] {
    S_REQUEST = 3'd0,
    S_WAIT    = 3'd1,
    S_HOLD    = 3'd2,
    S_DRAIN   = 3'd3,
    S_FAULT   = 3'd4
  } fetch_state_t;

  function automatic logic isWordAligned(input logic [INSTR_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch -- single-issue instruction fetch stage.
//
// Purpose:
//   Walks the PC through instruction memory one word at a time, keeping at
//   most one read in flight, and hands each fetched word to decode with a
//   valid/ready handshake. Redirects (branch, jump, trap) override
//   everything; a misaligned redirect target parks the stage in a fault
//   state until another redirect or reset arrives.
//
// Ports:
//   i_Clock            single clock, all state changes on its rising edge
//   i_Reset            synchronous active-high reset
//   i_Redirect         change the PC to i_RedirectTarget this cycle
//   i_RedirectTarget   new PC for a redirect
//   i_Ready            decode accepts the presented word this cycle
//   o_Valid            o_InstructionWord / o_PC hold a fetched instruction
//   o_InstructionWord  fetched instruction word
//   o_PC               address of o_InstructionWord, or the faulting target
//   o_MisalignedFetch  redirect target was not 4-byte aligned
//   o_MemReadEnable    one-cycle read request to instruction memory
//   o_MemAddress       read request address (the PC)
//   i_MemReadValid     memory response strobe
//   i_MemReadData      memory response word
// ---------------------------------------------------------------------------
module instruction_fetch
  import cpudefs::*;
#(
  parameter logic [INSTR_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Redirect,
  input  logic [INSTR_WIDTH-1:0] i_RedirectTarget,
  input  logic                   i_Ready,
  output logic                   o_Valid,
  output logic [INSTR_WIDTH-1:0] o_InstructionWord,
  output logic [INSTR_WIDTH-1:0] o_PC,
  output logic                   o_MisalignedFetch,
  output logic                   o_MemReadEnable,
  output logic [INSTR_WIDTH-1:0] o_MemAddress,
  input  logic                   i_MemReadValid,
  input  logic [INSTR_WIDTH-1:0] i_MemReadData
);

  fetch_state_t           state_q, state_d;
  logic [INSTR_WIDTH-1:0] pc_q, pc_d;
  logic                   pending_q, pending_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic [INSTR_WIDTH-1:0] outPc_q, outPc_d;
  logic                   memReq;
  logic                   respStrobe;

  // A response only means something if we are actually owed one; anything
  // that shows up with nothing pending is dropped on the floor here.
  assign respStrobe = i_MemReadValid && pending_q;

  // State register plus the PC, pending flag and the output holding
  // registers. Reset returns everything to a clean "about to fetch the
  // reset vector" condition; memory shares the same reset, so there is no
  // stale response to worry about afterwards.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_REQUEST;
      pc_q      <= RESET_VECTOR;
      pending_q <= 1'b0;
      word_q    <= '0;
      outPc_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      word_q    <= word_d;
      outPc_q   <= outPc_d;
    end
  end

  // Next-state logic. A redirect wins in every state: any response that
  // lands in the same cycle is treated as consumed-and-discarded, and if a
  // response is still owed afterwards we detour through S_DRAIN so the
  // stale word can never be mistaken for the new target's instruction.
  // A redirect in S_REQUEST suppresses that cycle's read so nothing is
  // left in flight for the old PC. A redirect in S_HOLD counts the held
  // word as consumed but the PC takes the target instead of PC+4.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    word_d    = word_q;
    outPc_d   = outPc_q;
    memReq    = 1'b0;

    if (i_Redirect) begin
      if (respStrobe) begin
        pending_d = 1'b0;
      end
      if (isWordAligned(i_RedirectTarget)) begin
        pc_d    = i_RedirectTarget;
        state_d = pending_d ? S_DRAIN : S_REQUEST;
      end else begin
        outPc_d = i_RedirectTarget;
        state_d = S_FAULT;
      end
    end else begin
      case (state_q)
        S_REQUEST: begin
          memReq    = 1'b1;
          pending_d = 1'b1;
          state_d   = S_WAIT;
        end
        S_WAIT: begin
          if (respStrobe) begin
            word_d    = i_MemReadData;
            outPc_d   = pc_q;
            pending_d = 1'b0;
            state_d   = S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_Ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQUEST;
          end
        end
        S_DRAIN: begin
          if (respStrobe) begin
            pending_d = 1'b0;
            state_d   = S_REQUEST;
          end
        end
        S_FAULT: begin
          if (respStrobe) begin
            pending_d = 1'b0;
          end
        end
        default: begin
          state_d = S_REQUEST;
        end
      endcase
    end
  end

  // Outputs are forced low for the whole time reset is held, not just
  // from the edge after it is first sampled, so downstream never sees a
  // bogus request or instruction while the core is being reset.
  assign o_Valid           = !i_Reset && (state_q == S_HOLD);
  assign o_MisalignedFetch = !i_Reset && (state_q == S_FAULT);
  assign o_MemReadEnable   = !i_Reset && memReq;
  assign o_MemAddress      = pc_q;
  assign o_InstructionWord = i_Reset ? '0 : word_q;
  assign o_PC              = i_Reset ? '0 : outPc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch -- self-checking bench for instruction_fetch.
//
// An instruction memory with variable latency answers the fetch stage. The
// reference model only tracks the architectural fetch stream: the next PC
// that decode should see, advancing by 4 per accepted instruction and
// jumping on redirects. Every instruction presented to decode is popped
// from the expected queue and compared against that stream.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] target = 32'h0;
  logic        ready = 1'b0;
  logic        memValid = 1'b0;
  logic [31:0] memData = 32'h0;

  logic        o_Valid;
  logic [31:0] o_InstructionWord;
  logic [31:0] o_PC;
  logic        o_MisalignedFetch;
  logic        o_MemReadEnable;
  logic [31:0] o_MemAddress;

  instruction_fetch #(.RESET_VECTOR(RV)) dut (
    .i_Clock          (clk),
    .i_Reset          (rst),
    .i_Redirect       (redirect),
    .i_RedirectTarget (target),
    .i_Ready          (ready),
    .o_Valid          (o_Valid),
    .o_InstructionWord(o_InstructionWord),
    .o_PC             (o_PC),
    .o_MisalignedFetch(o_MisalignedFetch),
    .o_MemReadEnable  (o_MemReadEnable),
    .o_MemAddress     (o_MemAddress),
    .i_MemReadValid   (memValid),
    .i_MemReadData    (memData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_t;

  fetch_t      expQ[$];
  fetch_t      held = '0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] expPc = RV;
  logic        faulted = 1'b0;
  logic [31:0] faultTarget = 32'h0;
  logic        memOut = 1'b0;
  int          memDue = 0;
  logic [31:0] memAddr = 32'h0;
  int          cyc = 0;
  int          latMin = 1;
  int          latMax = 1;
  bit          spurious = 1'b0;
  int          stall = 0;
  logic        prevValid = 1'b0;
  logic        prevReady = 1'b0;
  logic        prevRedirect = 1'b0;
  logic        prevRst = 1'b1;

  // Memory contents: a scrambled function of the address, with one known
  // instruction (addi x1,x0,5) planted at 0xC for the back-pressure phase.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic fetch_t mk(input logic [31:0] a);
    return {a, memWord(a)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge. The memory side
  // answers an outstanding read when its latency expires, and when enabled
  // occasionally fires a response nobody asked for.
  task automatic applyStimulus(input bit r, input bit rd, input logic [31:0] tgt,
                               input bit rdy);
    @(posedge clk);
    #1;
    cyc++;
    rst      = r;
    redirect = rd;
    target   = tgt;
    ready    = rdy;
    if (memOut && cyc == memDue) begin
      memValid = 1'b1;
      memData  = memWord(memAddr);
    end else if (!memOut && spurious && $urandom_range(0, 19) == 0) begin
      memValid = 1'b1;
      memData  = $urandom();
    end else begin
      memValid = 1'b0;
      memData  = $urandom();
    end
  endtask

  task automatic waitForRequest();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      if (o_MemReadEnable) seen = 1'b1;
    end
    if (!seen) checkOutput("requestTimeout", {31'b0, seen}, 32'd1);
  endtask

  // Monitor: samples at the falling edge, checks reset values, fault
  // behaviour and request addresses, and pops the scoreboard whenever a
  // new instruction is presented to decode.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      checkOutput("resetValid", {31'b0, o_Valid}, 32'd0);
      checkOutput("resetMisaligned", {31'b0, o_MisalignedFetch}, 32'd0);
      checkOutput("resetMemEnable", {31'b0, o_MemReadEnable}, 32'd0);
      checkOutput("resetWord", o_InstructionWord, 32'd0);
      checkOutput("resetPc", o_PC, 32'd0);
    end else begin
      if (faulted) begin
        checkOutput("faultFlag", {31'b0, o_MisalignedFetch}, 32'd1);
        checkOutput("faultPc", o_PC, faultTarget);
        checkOutput("faultValid", {31'b0, o_Valid}, 32'd0);
        checkOutput("faultMemEnable", {31'b0, o_MemReadEnable}, 32'd0);
      end else begin
        checkOutput("misalignedIdle", {31'b0, o_MisalignedFetch}, 32'd0);
        if (o_MemReadEnable) begin
          checkOutput("memAddress", o_MemAddress, expPc);
          checkOutput("oneOutstanding", {31'b0, memOut}, 32'd0);
        end
      end
      if (!prevRst && (prevRedirect || (prevValid && prevReady))) begin
        checkOutput("validDrop", {31'b0, o_Valid}, 32'd0);
      end else if (!prevRst && prevValid) begin
        checkOutput("holdValid", {31'b0, o_Valid}, 32'd1);
        checkOutput("holdPc", o_PC, held.pc);
        checkOutput("holdWord", o_InstructionWord, held.word);
      end else if (o_Valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedValid", {31'b0, o_Valid}, 32'd0);
        end else begin
          held = expQ.pop_front();
          checkOutput("fetchPc", o_PC, held.pc);
          checkOutput("fetchWord", o_InstructionWord, held.word);
        end
      end
    end
    prevValid    = o_Valid;
    prevReady    = ready;
    prevRedirect = redirect;
    prevRst      = rst;
  end

  // Reference model and memory bookkeeping, updated just after the monitor
  // so this cycle's checks see last cycle's expectations. The architectural
  // PC advances on each accepted instruction and jumps on redirects; a
  // misaligned target parks the model in the fault condition.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      expPc   = RV;
      faulted = 1'b0;
      expQ.delete();
      expQ.push_back(mk(RV));
      memOut  = 1'b0;
      stall   = 0;
    end else begin
      if (memValid) memOut = 1'b0;
      if (o_MemReadEnable) begin
        memOut  = 1'b1;
        memAddr = o_MemAddress;
        memDue  = cyc + $urandom_range(latMin, latMax);
      end
      if (redirect) begin
        expQ.delete();
        if (target[1:0] != 2'b00) begin
          faulted     = 1'b1;
          faultTarget = target;
        end else begin
          faulted = 1'b0;
          expPc   = target;
          expQ.push_back(mk(target));
        end
      end else if (o_Valid && ready) begin
        expPc = expPc + 32'd4;
        expQ.push_back(mk(expPc));
      end
      if (faulted || o_Valid || redirect) stall = 0;
      else stall++;
      if (stall > 20) begin
        checkOutput("fetchStall", stall, 32'd0);
        stall = 0;
      end
    end
  end

  // Directed phases first (sequential fetch, back-pressure, redirect with
  // a stale response, misaligned target, PC wrap, reset mid-transaction),
  // then a long randomized run.
  initial begin
    bit          r;
    bit          rd;
    bit          rdy;
    logic [31:0] tgt;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

    latMin = 1; latMax = 1;
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    latMin = 3; latMax = 3;
    waitForRequest();
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    applyStimulus(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    latMin = 1; latMax = 2;
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    latMin = 3; latMax = 3;
    waitForRequest();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    latMin = 1; latMax = 4;
    spurious = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      rd  = !r && ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(r, rd, tgt, rdy);
    end

    spurious = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter SHALL be RESET_VECTOR, default 32'h0000_0000, the PC loaded on reset.
REQ-002 Port SHALL be i_Clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port SHALL be i_Reset  input  1  synchronous, active-high reset.
REQ-004 Port SHALL be i_Redirect  input  1  request to change the PC (from branch/jump/trap).
REQ-005 Port SHALL be i_RedirectTarget  input  32  new PC when i_Redirect=1.
REQ-006 Port SHALL be i_Ready  input  1  decode stage accepts o_InstructionWord this cycle.
REQ-007 Port SHALL be o_Valid  output  1  o_InstructionWord/o_PC hold a fetched instruction.
REQ-008 Port SHALL be o_InstructionWord  output  32  fetched word, sent to decode's i_InstructionWord.
REQ-009 Port SHALL be o_PC  output  32  address of o_InstructionWord, or faulting target in S_FAULT.
REQ-010 Port SHALL be o_MisalignedFetch  output  1  redirect target not 4-byte aligned.
REQ-011 Port SHALL be o_MemReadEnable  output  1  one-cycle instruction-memory read request.
REQ-012 Port SHALL be o_MemAddress  output  32  request address, equal to the PC.
REQ-013 Port SHALL be i_MemReadValid  input  1  response strobe, at least 1 cycle after request.
REQ-014 Port SHALL be i_MemReadData  input  32  response word, valid with i_MemReadValid.

Function
REQ-015 FSM SHALL have states S_REQUEST, S_WAIT, S_HOLD, S_DRAIN, S_FAULT; at most one memory request outstanding.
REQ-016 S_REQUEST: o_MemReadEnable=1 and o_MemAddress=PC for exactly one cycle, set r_Pending, go S_WAIT.
REQ-017 S_WAIT: on i_MemReadValid, register i_MemReadData and PC into the output registers, clear r_Pending, go S_HOLD; otherwise remain.
REQ-018 Latency: request in cycle N, response in N+k (k>=1), o_Valid=1 in N+k+1.
REQ-019 S_HOLD: o_Valid=1; o_InstructionWord and o_PC stable while i_Ready=0; on i_Ready=1 the word is consumed, PC<=PC+4, go S_REQUEST.
REQ-020 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no fault.
REQ-021 i_Redirect SHALL take priority in every state; o_Valid=0 from the next cycle.
REQ-022 On redirect with i_RedirectTarget[1:0]==0: PC<=target; next state S_REQUEST if no response is outstanding (r_Pending=0, or i_MemReadValid in the same cycle), else S_DRAIN.
REQ-023 S_DRAIN: no request issued; discard the stale response on i_MemReadValid, clear r_Pending, go S_REQUEST.
REQ-024 On redirect with i_RedirectTarget[1:0]!=0: go S_FAULT, o_MisalignedFetch=1, o_PC=target, o_Valid=0, no requests.
REQ-025 S_FAULT SHALL silently absorb any outstanding response and exit only on another redirect or reset.
REQ-026 Redirect and i_Ready both high in S_HOLD: the held word counts as consumed; PC takes the target, not PC+4.
REQ-027 Any response arriving while r_Pending=0 SHALL be ignored.

Reset
REQ-028 While i_Reset=1: PC<=RESET_VECTOR, r_Pending<=0, state<=S_REQUEST, and o_Valid, o_MisalignedFetch, o_MemReadEnable, o_InstructionWord, o_PC are all 0.
REQ-029 The first request SHALL issue in the first cycle after i_Reset falls.
REQ-030 Reset mid-S_WAIT SHALL abort the transaction; instruction memory shares i_Reset and delivers no stale response.

Structure
REQ-031 Package cpudefs SHALL hold the fetch_state_t enum, the default reset-vector constant and the instruction-width constant.
REQ-032 The block is a single module; no sub-module is required.

Verification
REQ-033 Reset then memory latency 1, i_Ready=1: requests at 0x0, 0x4, 0x8; o_Valid pulses with the matching o_PC; one instruction per 3 cycles.
REQ-034 Back-pressure: i_Ready=0 for 5 cycles in S_HOLD with word 0x00500093 -> o_InstructionWord stable, no new request, PC advances only after i_Ready=1.
REQ-035 Redirect to 0x100 during S_WAIT with response 3 cycles later -> stale word never appears on o_Valid; next request address is 0x100.
REQ-036 Redirect to 0x102 -> o_MisalignedFetch=1, o_PC=0x102, no o_MemReadEnable; a later redirect to 0x200 resumes fetch at 0x200.
REQ-037 PC=0xFFFFFFFC consumed -> next o_MemAddress=0x00000000.
REQ-038 Assert i_Reset during S_WAIT -> all outputs 0 next cycle; first post-reset request address is RESET_VECTOR.
